// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake bundle for muldiv_unit
// master drives requests (flush, in_valid, op, data1, data2, in_tag) and out_ready;
// slave answers with in_ready, out_valid, result and out_tag.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  data1;
  logic [XLEN-1:0]  data2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output flush, in_valid, op, data1, data2, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag
  );
  modport slave (
    input  flush, in_valid, op, data1, data2, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, 1 bit per cycle
// clk: rising-edge clock; reset: async active-high reset;
// bus: muldiv_if slave port carrying request (op/data1/data2/in_tag) and result handshakes plus flush.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  logic [XLEN-1:0]   a;
  logic [2*XLEN-1:0] acc;
  logic              neg_q, neg_r;
  logic              sdiv, s1, s2, n1, n2, dz, ovf, accept;
  logic [XLEN-1:0]   m1, m2, byp, quo, rem, res;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] prod;
  always_comb begin
    sdiv     = bus.op[2] & ~bus.op[0];
    s1       = sdiv | (bus.op == 3'b001) | (bus.op == 3'b010);
    s2       = sdiv | (bus.op == 3'b001);
    n1       = s1 & bus.data1[XLEN-1];
    n2       = s2 & bus.data2[XLEN-1];
    m1       = n1 ? -bus.data1 : bus.data1;
    m2       = n2 ? -bus.data2 : bus.data2;
    dz       = bus.op[2] && bus.data2 == '0;
    ovf      = sdiv && bus.data1 == {1'b1, {(XLEN-1){1'b0}}} && bus.data2 == '1;
    byp      = dz ? (bus.op[1] ? bus.data1 : '1) : (bus.op[1] ? '0 : bus.data1);
    accept   = bus.in_valid && bus.in_ready && !bus.flush;
    // multiply: acc = {partial high, remaining multiplier bits}, shifted right each step
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a} : '0);
    // divide: acc = {remainder, dividend bits being replaced by quotient bits}
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, a};
    prod     = neg_q ? -acc : acc;
    quo      = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem      = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    res      = op_q[2] ? (op_q[1] ? rem : quo)
                       : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op_q          <= '0;
      tag_q         <= '0;
      a             <= '0;
      acc           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.out_tag   <= '0;
    end else if (bus.flush) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.out_tag   <= '0;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            op_q         <= bus.op;
            tag_q        <= bus.in_tag;
            neg_q        <= n1 ^ n2;
            neg_r        <= n1;
            a            <= bus.op[2] ? m2 : m1;
            acc          <= {{XLEN{1'b0}}, bus.op[2] ? m1 : m2};
            cnt          <= CW'(XLEN - 1);
            bus.in_ready <= 1'b0;
            if (dz || ovf) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.result    <= byp;
              bus.out_tag   <= bus.in_tag;
            end else begin
              state <= CALC;
            end
          end else begin
            bus.in_ready <= 1'b1;
          end
        CALC: begin
          acc   <= op_q[2] ? {rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0],
                              acc[XLEN-2:0], ~rem_diff[XLEN]}
                           : {mul_sum, acc[XLEN-1:1]};
          cnt   <= cnt == '0 ? '0 : cnt - 1'b1;
          state <= cnt == '0 ? FIX : CALC;
        end
        FIX: begin
          state         <= DONE;
          bus.out_valid <= 1'b1;
          bus.result    <= res;
          bus.out_tag   <= tag_q;
        end
        DONE:
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.out_tag   <= '0;
          end
      endcase
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (vector table, corner sequences, random vs model)
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  muldiv_if #(.XLEN(32), .TAG_W(5)) bus();
  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_checks = 0;
  int n_fails = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  tag;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0] ux, uy, p;
    logic ovf;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    ovf = x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
    case (op)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * $signed(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin p = sx / sy; return y == 0 ? 32'hFFFF_FFFF : ovf ? x : p[31:0]; end
      3'd5: begin p = ux / uy; return y == 0 ? 32'hFFFF_FFFF : p[31:0]; end
      3'd6: begin p = sx % sy; return y == 0 ? x : ovf ? 32'h0 : p[31:0]; end
      default: begin p = ux % uy; return y == 0 ? x : p[31:0]; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    return (op[2] && (y == 0 || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) ? 1 : 34;
  endfunction

  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 7);
    return k == 0 ? 32'h0 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'h8000_0000 :
           k == 3 ? 32'($urandom_range(0, 20)) : 32'($urandom);
  endfunction

  task automatic start_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic [4:0] tag);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.data1    = x;
    bus.data2    = y;
    bus.in_tag   = tag;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data1    = $urandom;
    bus.data2    = $urandom;
    bus.in_tag   = 5'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                           input logic [4:0] tag, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(op, x, y, tag);
    wait_result(lat);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_result"}, bus.result, exp);
    check({name, "_tag"}, bus.out_tag, tag);
    @(negedge clk);
    check({name, "_consumed"}, {bus.out_valid, bus.in_ready, bus.result}, {2'b01, 32'h0});
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    check(name, seen, 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] x, y, r;
    logic [4:0]  t;
    int          lat;
    vecs = '{
      '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 34},
      '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 34},
      '{3'b010, 32'hFFFF_FFFF,  32'd2,         5'd5,  32'hFFFF_FFFF, 34},
      '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 34},
      '{3'b101, 32'd100,        32'd7,         5'd7,  32'd14,        34},
      '{3'b111, 32'd100,        32'd7,         5'd8,  32'd2,         34},
      '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 34},
      '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 34},
      '{3'b100, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1},
      '{3'b110, 32'd5,          32'd0,         5'd12, 32'd5,         1},
      '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1},
      '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h0,         1}
    };
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.data1     = '0;
    bus.data2     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.out_valid, bus.result, bus.out_tag}, '0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.in_ready, 1);
    for (int i = 0; i < 12; i++)
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].tag, vecs[i].res, vecs[i].lat);
    // result held while consumer stalls
    bus.out_ready = 1'b0;
    start_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd21);
    wait_result(lat);
    check("stall_latency", 64'(lat), 64'd34);
    check("stall_result", bus.result, 32'hFFFF_FFFD);
    r = bus.result;
    t = bus.out_tag;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_stable", {bus.out_valid, bus.in_ready, bus.result, bus.out_tag}, {2'b10, r, t});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("stall_release", {bus.out_valid, bus.in_ready, bus.result, bus.out_tag}, {2'b01, 32'h0, 5'h0});
    bus.out_ready = 1'b1;
    // flush in the 5th CALC cycle
    start_op(3'b101, 32'd1000, 32'd7, 5'd17);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    watch_no_valid("flush_no_valid", 50);
    run_check("after_flush", 3'b101, 32'd9, 32'd3, 5'd18, 32'd3, 34);
    // reset in the 5th CALC cycle
    start_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd19);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_calc", {bus.out_valid, bus.result, bus.out_tag}, '0);
    reset = 1'b0;
    watch_no_valid("reset_no_valid", 50);
    run_check("after_reset", 3'b101, 32'd9, 32'd3, 5'd20, 32'd3, 34);
    // flush beats a simultaneous request
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    bus.op       = 3'b101;
    bus.data1    = 32'd9;
    bus.data2    = 32'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_beats_accept", bus.in_ready, 1);
    watch_no_valid("flush_accept_no_valid", 40);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = pick();
      y  = pick();
      t  = 5'($urandom);
      run_check($sformatf("rand%0d_op%0d_%h_%h", i, op, x, y), op, x, y, t, model(op, x, y), model_lat(op, x, y));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
